// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator and its median-filter consumer.
// The window is packed row-major, top row first, left column in the MSBs.
package window_gen_3x3_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_W    = 9 * PIX_W;
    localparam int TAP_ROWS = 3;
    localparam int TAP_COLS = 3;

    // Row 0 is y-2 and column 0 is x-2; the centre tap sits at row 1, column 1.
    localparam int TAP_CENTRE_LSB = 4 * PIX_W;

    function automatic int tap_lsb(input int row, input int col);
        return (8 - (row * TAP_COLS + col)) * PIX_W;
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// Single-row pixel store: asynchronous read and synchronous write, so a read and
// a write to the same column in one cycle return the old contents.
module window_gen_3x3_line_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic                                 clk,
    input  logic                                 i_we,
    input  logic [AW-1:0]                        i_addr,
    input  logic [window_gen_3x3_pkg::PIX_W-1:0] i_wdata,
    output logic [window_gen_3x3_pkg::PIX_W-1:0] o_rdata
);
    import window_gen_3x3_pkg::*;

    logic [PIX_W-1:0] r_mem [0:DEPTH-1];

    assign o_rdata = r_mem[i_addr];

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 tap array
// feed a single-entry registered output with valid/ready backpressure.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_W-1:0]     in_pixel,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic [9*PIX_W-1:0]   window,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);
    import window_gen_3x3_pkg::*;

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [PIX_W-1:0]   r_tap [0:2][0:2];
    logic [WIN_W-1:0]   r_window;
    logic               r_out_valid;
    logic               r_out_last;

    logic               w_accept;
    logic [XW-1:0]      w_x;
    logic [YW-1:0]      w_y;
    logic               w_x_end;
    logic               w_y_end;
    logic               w_produce;
    logic [PIX_W-1:0]   w_a;
    logic [PIX_W-1:0]   w_b;
    logic [PIX_W-1:0]   w_next_tap [0:2][0:2];
    logic [WIN_W-1:0]   w_win_next;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_x       = in_sof ? {XW{1'b0}} : r_x;
    assign w_y       = in_sof ? {YW{1'b0}} : r_y;
    assign w_x_end   = (w_x == XW'(IMG_WIDTH - 1));
    assign w_y_end   = (w_y == YW'(IMG_HEIGHT - 1));
    assign w_produce = (w_x >= XW'(2)) && (w_y >= YW'(2));

    window_gen_3x3_line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_x),
        .i_wdata (in_pixel),
        .o_rdata (w_b)
    );

    window_gen_3x3_line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_x),
        .i_wdata (w_b),
        .o_rdata (w_a)
    );

    // Shifted tap array and the packed window it would form after this accept.
    always_comb begin
        w_win_next = {WIN_W{1'b0}};
        for (int r = 0; r < TAP_ROWS; r++) begin
            w_next_tap[r][0] = r_tap[r][1];
            w_next_tap[r][1] = r_tap[r][2];
        end
        w_next_tap[0][2] = w_a;
        w_next_tap[1][2] = w_b;
        w_next_tap[2][2] = in_pixel;
        for (int r = 0; r < TAP_ROWS; r++) begin
            for (int c = 0; c < TAP_COLS; c++) begin
                w_win_next[tap_lsb(r, c) +: PIX_W] = w_next_tap[r][c];
            end
        end
    end

    // Raster position of the next expected pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= {XW{1'b0}};
            r_y <= {YW{1'b0}};
        end else if (w_accept) begin
            r_x <= w_x_end ? {XW{1'b0}} : w_x + XW'(1);
            if (w_x_end) begin
                r_y <= w_y_end ? {YW{1'b0}} : w_y + YW'(1);
            end else begin
                r_y <= w_y;
            end
        end
    end

    // Tap columns shift left on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < TAP_ROWS; r++) begin
                for (int c = 0; c < TAP_COLS; c++) begin
                    r_tap[r][c] <= {PIX_W{1'b0}};
                end
            end
        end else if (w_accept) begin
            r_tap <= w_next_tap;
        end
    end

    // Output register: load on an interior accept, retire on ready, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window    <= {WIN_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept && w_produce) begin
            r_window    <= w_win_next;
            r_out_valid <= 1'b1;
            r_out_last  <= w_x_end && w_y_end;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign window    = r_window;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 image, with a median check standing
// in for the downstream filter.
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [71:0] window;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    logic [71:0] q_win [$];
    logic        q_last [$];

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .window    (window),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // A window is consumed at the next rising edge whenever valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_win.push_back(window);
            q_last.push_back(out_last);
        end
    end

    function automatic logic [7:0] pix(input int base, input int c, input int r);
        return 8'(base + r * W + c);
    endfunction

    function automatic logic [71:0] exp_win(input int base, input int x, input int y);
        logic [71:0] w;
        w = 72'h0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w = {w[63:0], pix(base, x - 2 + c, y - 2 + r)};
            end
        end
        return w;
    endfunction

    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] v [0:8];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) v[i] = w[i*8 +: 8];
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        return v[4];
    endfunction

    task automatic send_pixel(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        in_pixel = p;
        in_valid = 1'b1;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                send_pixel(pix(base, x, y), (x == 0 && y == 0));
            end
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int offset, input int base);
        int x, y;
        for (int i = 0; i < 6; i++) begin
            x = 2 + i % 3;
            y = 2 + i / 3;
            checks++;
            if (offset + i >= q_win.size()) begin
                failures++;
                $display("FAIL %s_missing: window %0d not seen, got %0d windows", name, i, q_win.size());
            end else begin
                if (q_win[offset+i] !== exp_win(base, x, y)) begin
                    failures++;
                    $display("FAIL %s_win%0d: got %h required %h", name, i, q_win[offset+i], exp_win(base, x, y));
                end
                checks++;
                if (q_last[offset+i] !== (i == 5)) begin
                    failures++;
                    $display("FAIL %s_last%0d: got %b required %b", name, i, q_last[offset+i], (i == 5));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_pixel  = 8'h00;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || window !== 72'h0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b w=%h required 0/0/0", out_valid, out_last, window);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        q_win.delete();
        q_last.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                send_pixel(pix(0, x, y), (x == 0 && y == 0));
                if (x == 1 && y == 2) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL basic_early_valid: got %b required 0", out_valid);
                    end
                end
                if (x == 2 && y == 2) begin
                    checks++;
                    if (out_valid !== 1'b1 || window !== 72'h000102_050607_0A0B0C) begin
                        failures++;
                        $display("FAIL basic_first: got v=%b w=%h required 1 000102050607_0A0B0C", out_valid, window);
                    end
                end
            end
        end
        drain();
        checks++;
        if (q_win.size() != 6) begin
            failures++;
            $display("FAIL basic_count: got %0d required 6", q_win.size());
        end
        checks++;
        if (q_win.size() < 6 || q_win[5] !== 72'h070809_0C0D0E_111213 || q_last[5] !== 1'b1) begin
            failures++;
            $display("FAIL basic_lastwin: got %0d windows, final %h, required 0708090C0D0E111213 with last", q_win.size(), (q_win.size() > 0) ? q_win[q_win.size()-1] : 72'h0);
        end
        check_frame("basic", 0, 0);
    endtask

    task automatic test_backpressure();
        logic [71:0] held;
        int n;
        q_win.delete();
        q_last.delete();
        fork
            send_frame(0);
            begin
                n = 0;
                @(posedge clk);
                #1;
                while (!out_valid && n < 200) begin
                    n++;
                    @(posedge clk);
                    #1;
                end
                held = window;
                out_ready = 1'b0;
                checks++;
                if (out_valid !== 1'b1 || held !== 72'h000102_050607_0A0B0C) begin
                    failures++;
                    $display("FAIL bp_first: got v=%b w=%h required 1 000102050607_0A0B0C", out_valid, held);
                end
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || window !== held) begin
                        failures++;
                        $display("FAIL bp_hold: got rdy=%b v=%b w=%h required 0 1 %h", in_ready, out_valid, window, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (q_win.size() != 6) begin
            failures++;
            $display("FAIL bp_count: got %0d required 6", q_win.size());
        end
        check_frame("bp", 0, 0);
    endtask

    task automatic test_back_to_back();
        q_win.delete();
        q_last.delete();
        send_frame(0);
        send_frame(100);
        drain();
        checks++;
        if (q_win.size() != 12) begin
            failures++;
            $display("FAIL b2b_count: got %0d required 12", q_win.size());
        end
        check_frame("b2b_f0", 0, 0);
        check_frame("b2b_f1", 6, 100);
        checks++;
        if (q_win.size() < 7 || q_win[6][71:64] !== 8'd100) begin
            failures++;
            $display("FAIL b2b_f1_topleft: got %h required 64", (q_win.size() > 6) ? q_win[6][71:64] : 8'h00);
        end
    endtask

    task automatic test_reset_resync();
        q_win.delete();
        q_last.delete();
        for (int i = 0; i <= 12; i++) begin
            send_pixel(pix(0, i % W, i / W), (i == 0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || window !== 72'h0) begin
            failures++;
            $display("FAIL resync_async: got v=%b l=%b w=%h required 0/0/0", out_valid, out_last, window);
        end
        checks++;
        if (dut.r_x !== 3'd0 || dut.r_y !== 2'd0) begin
            failures++;
            $display("FAIL resync_counters: got x=%0d y=%0d required 0 0", dut.r_x, dut.r_y);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_win.delete();
        q_last.delete();
        send_frame(0);
        drain();
        checks++;
        if (q_win.size() != 6) begin
            failures++;
            $display("FAIL resync_count: got %0d required 6", q_win.size());
        end
        check_frame("resync", 0, 0);
    endtask

    task automatic test_median();
        q_win.delete();
        q_last.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                send_pixel((x == 2 && y == 2) ? 8'hFF : 8'h40, (x == 0 && y == 0));
            end
        end
        drain();
        checks++;
        if (q_win.size() != 6) begin
            failures++;
            $display("FAIL median_count: got %0d required 6", q_win.size());
        end
        checks++;
        if (q_win.size() < 1 || q_win[0] !== 72'h404040_404040_4040FF) begin
            failures++;
            $display("FAIL median_impulse_win: got %h required 4040404040404040FF", (q_win.size() > 0) ? q_win[0] : 72'h0);
        end
        for (int i = 0; i < q_win.size(); i++) begin
            checks++;
            if (median9(q_win[i]) !== 8'h40) begin
                failures++;
                $display("FAIL median_out%0d: got %h required 40", i, median9(q_win[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_resync();
        test_median();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
